// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding-select codes, reserved register address and select helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_ALU_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB  = 2'b10;

    // x0 is hardwired to zero, so it is never a hazard source
    localparam int REG_ADDR_RESET = 0;

    // Youngest producer wins; a load in ALU has no result to forward yet
    function automatic logic [1:0] fwd_pick(
        input logic alu_hit,
        input logic alu_is_load,
        input logic mem_hit
    );
        if (alu_hit && !alu_is_load) begin
            return FWD_ALU_MEM;
        end
        if (mem_hit) begin
            return FWD_MEM_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Compares one decode source register against one in-flight shadow slot.
// Ports: decode valid/use/address in, slot valid/we/rd in, hit_o out.
module pipe_hazard_ctrl_hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              dec_valid_i,
    input  logic              rs_use_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic              slot_valid_i,
    input  logic              slot_we_i,
    input  logic [ADDR_W-1:0] slot_rd_i,
    output logic              hit_o
);

    logic src_live;

    assign src_live = slot_valid_i & slot_we_i
                    & (slot_rd_i != ADDR_W'(REG_ADDR_RESET));

    assign hit_o = dec_valid_i & rs_use_i & src_live
                 & (rs_addr_i == slot_rd_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: issue/stall/bubble/flush, MUL and MEM
// freezes, registered forwarding selects. Ports: clk_i, resetIn_i (sync,
// active low), dec* decode info, aluBranchTaken_i, memReady_i in;
// stall*/flush/bubble controls and fwdSel1_o/fwdSel2_o out.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4
) (
    input  logic                  clk_i,
    input  logic                  resetIn_i,
    input  logic                  decValid_i,
    input  logic [REG_ADDR_W-1:0] decRs1Addr_i,
    input  logic [REG_ADDR_W-1:0] decRs2Addr_i,
    input  logic                  decRs1Use_i,
    input  logic                  decRs2Use_i,
    input  logic [REG_ADDR_W-1:0] decRdAddr_i,
    input  logic                  decWriteEnable_i,
    input  logic                  decIsLoad_i,
    input  logic                  decIsMul_i,
    input  logic                  aluBranchTaken_i,
    input  logic                  memReady_i,
    output logic                  stallFetch_o,
    output logic                  stallDec_o,
    output logic                  flushFetchDec_o,
    output logic                  bubbleDecAlu_o,
    output logic                  stallAlu_o,
    output logic [1:0]            fwdSel1_o,
    output logic [1:0]            fwdSel2_o
);

    localparam int CNT_W = $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } slot_t;

    // index 0 = ALU, 1 = MEM, 2 = WB
    slot_t      shadow_q [3];
    slot_t      shadow_d [3];
    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] fwd1_q, fwd1_d;
    logic [1:0] fwd2_q, fwd2_d;

    logic hit1_alu, hit1_mem, hit2_alu, hit2_mem;
    logic mem_wait, load_use;

    pipe_hazard_ctrl_hazard_match #(.ADDR_W(REG_ADDR_W)) u_m1_alu (
        .dec_valid_i (decValid_i),
        .rs_use_i    (decRs1Use_i),
        .rs_addr_i   (decRs1Addr_i),
        .slot_valid_i(shadow_q[0].valid),
        .slot_we_i   (shadow_q[0].we),
        .slot_rd_i   (shadow_q[0].rd),
        .hit_o       (hit1_alu)
    );

    pipe_hazard_ctrl_hazard_match #(.ADDR_W(REG_ADDR_W)) u_m1_mem (
        .dec_valid_i (decValid_i),
        .rs_use_i    (decRs1Use_i),
        .rs_addr_i   (decRs1Addr_i),
        .slot_valid_i(shadow_q[1].valid),
        .slot_we_i   (shadow_q[1].we),
        .slot_rd_i   (shadow_q[1].rd),
        .hit_o       (hit1_mem)
    );

    pipe_hazard_ctrl_hazard_match #(.ADDR_W(REG_ADDR_W)) u_m2_alu (
        .dec_valid_i (decValid_i),
        .rs_use_i    (decRs2Use_i),
        .rs_addr_i   (decRs2Addr_i),
        .slot_valid_i(shadow_q[0].valid),
        .slot_we_i   (shadow_q[0].we),
        .slot_rd_i   (shadow_q[0].rd),
        .hit_o       (hit2_alu)
    );

    pipe_hazard_ctrl_hazard_match #(.ADDR_W(REG_ADDR_W)) u_m2_mem (
        .dec_valid_i (decValid_i),
        .rs_use_i    (decRs2Use_i),
        .rs_addr_i   (decRs2Addr_i),
        .slot_valid_i(shadow_q[1].valid),
        .slot_we_i   (shadow_q[1].we),
        .slot_rd_i   (shadow_q[1].rd),
        .hit_o       (hit2_mem)
    );

    assign mem_wait = shadow_q[1].valid & ~memReady_i;
    assign load_use = shadow_q[0].is_load & (hit1_alu | hit2_alu);

    // RUN and MEM_WAIT share one decision chain: the memory hold has top
    // priority, so the release cycle falls straight through to issue.
    always_comb begin
        stallFetch_o    = 1'b0;
        stallDec_o      = 1'b0;
        flushFetchDec_o = 1'b0;
        bubbleDecAlu_o  = 1'b0;
        stallAlu_o      = 1'b0;
        state_d         = state_q;
        cnt_d           = cnt_q;
        shadow_d        = shadow_q;
        fwd1_d          = fwd1_q;
        fwd2_d          = fwd2_q;

        if (!resetIn_i) begin
            flushFetchDec_o = 1'b1;
            bubbleDecAlu_o  = 1'b1;
        end else if (state_q == ST_MUL_WAIT) begin
            stallFetch_o = 1'b1;
            stallDec_o   = 1'b1;
            stallAlu_o   = 1'b1;
            cnt_d        = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
                state_d = ST_RUN;
            end
        end else if (mem_wait) begin
            stallFetch_o = 1'b1;
            stallDec_o   = 1'b1;
            stallAlu_o   = 1'b1;
            state_d      = ST_MEM_WAIT;
        end else if (aluBranchTaken_i || load_use) begin
            // both inject a bubble into ALU; only a branch kills IF/DEC
            flushFetchDec_o = aluBranchTaken_i;
            stallFetch_o    = ~aluBranchTaken_i;
            stallDec_o      = ~aluBranchTaken_i;
            bubbleDecAlu_o  = 1'b1;
            shadow_d[0]     = '0;
            shadow_d[1]     = shadow_q[0];
            shadow_d[2]     = shadow_q[1];
            fwd1_d          = FWD_RF;
            fwd2_d          = FWD_RF;
            state_d         = ST_RUN;
        end else begin
            shadow_d[0] = '{valid:   decValid_i,
                            rd:      decRdAddr_i,
                            we:      decWriteEnable_i,
                            is_load: decIsLoad_i};
            shadow_d[1] = shadow_q[0];
            shadow_d[2] = shadow_q[1];
            fwd1_d      = fwd_pick(hit1_alu, shadow_q[0].is_load, hit1_mem);
            fwd2_d      = fwd_pick(hit2_alu, shadow_q[0].is_load, hit2_mem);
            state_d     = ST_RUN;
            if (decValid_i && decIsMul_i) begin
                state_d = ST_MUL_WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetIn_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            shadow_q[0] <= '0;
            shadow_q[1] <= '0;
            shadow_q[2] <= '0;
            fwd1_q      <= FWD_RF;
            fwd2_q      <= FWD_RF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q[0] <= shadow_d[0];
            shadow_q[1] <= shadow_d[1];
            shadow_q[2] <= shadow_d[2];
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
        end
    end

    assign fwdSel1_o = fwd1_q;
    assign fwdSel2_o = fwd2_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline controller for the five-stage core: sequences the DEC_ALU pipeline register and its neighbours by deciding, every cycle, whether the decode stage issues, stalls, is bubbled or is flushed. Tracks in-flight destination registers in a shadow of the ALU, MEM and WB stages to detect load-use hazards and generate operand-forwarding selects. Freezes the pipeline for multi-cycle multiplies and slow data-memory accesses. Sits beside the decoder and drives the stall, reset and flush inputs of the IF/DEC and DEC_ALU registers.

## Interface
- REG_ADDR_W, 5, register address width
- MUL_LAT, 4, ALU multiply latency in cycles (≥2)
- clk  in  1  core clock
- resetIn  in  1  synchronous, active-low reset
- decValid  in  1  DEC stage holds a valid instruction
- decRs1Addr, decRs2Addr  in  REG_ADDR_W  source register addresses
- decRs1Use, decRs2Use  in  1  source actually read by the instruction
- decRdAddr  in  REG_ADDR_W  destination address
- decWriteEnable  in  1  instruction writes rd
- decIsLoad, decIsMul  in  1  instruction class flags
- aluBranchTaken  in  1  ALU-stage instruction redirects the PC
- memReady  in  1  data memory completes the MEM-stage access this cycle
- stallFetch, stallDec  out  1  hold PC and IF/DEC register
- flushFetchDec  out  1  kill IF/DEC contents
- bubbleDecAlu  out  1  drive DEC_ALU reset path (inject NOP, write denied)
- stallAlu  out  1  hold DEC_ALU and ALU_MEM registers
- fwdSel1, fwdSel2  out  2  operand source for the ALU next cycle: 00 register file, 01 ALU_MEM result, 10 MEM_WB result

## Operation
- FSM states: RUN, MUL_WAIT, MEM_WAIT. Mul counter width clog2(MUL_LAT).
- Shadow slots aluSlot, memSlot, wbSlot: {valid, rd, we, isLoad}. Slot counts as a hazard source only if valid, we, rd≠0.
- Hazard match: decValid & decRsNUse & decRsNAddr==slot.rd.
- Priority in RUN (highest first): MEM_WAIT entry, branch flush, load-use, issue.
- MEM_WAIT entry: memSlot.valid & !memReady → all stalls high, bubbleDecAlu 0, shadow frozen; go MEM_WAIT. Leave to RUN on the cycle memReady=1 (that cycle advances normally).
- Branch flush: aluBranchTaken → flushFetchDec=1, bubbleDecAlu=1, no stalls; aluSlot←invalid.
- Load-use: match against aluSlot with isLoad → stallFetch=stallDec=1, bubbleDecAlu=1; aluSlot←invalid. Exactly one bubble per hazard.
- Issue: aluSlot←decoded instruction (valid=decValid); memSlot←aluSlot; wbSlot←memSlot. If decIsMul, go MUL_WAIT, counter←MUL_LAT-1.
- MUL_WAIT: stallFetch, stallDec, stallAlu high, shadow frozen; counter decrements; at 0 return to RUN (that cycle stalls released). aluBranchTaken and memReady ignored.
- Forwarding (registered, loaded on issue, 00 on bubble/flush, held on stall): match aluSlot (non-load) → 01; else match memSlot → 10; else 00. aluSlot wins over memSlot. rd=0 never forwards.

## Timing
- Reset (resetIn=0 at clk edge): state RUN, slots invalid, counter 0, fwdSel 00. While resetIn=0, combinational outputs: stalls 0, flushFetchDec 1, bubbleDecAlu 1.
- Control outputs combinational from state, slots and current inputs; zero-cycle response. fwdSel valid one cycle after issue, aligned with DEC_ALU outputs.
- Load-use costs exactly 1 cycle; MUL costs MUL_LAT-1 stall cycles after issue; MEM wait lasts until memReady.
- Reset mid-MUL_WAIT or MEM_WAIT: abandons state immediately, no residual stall.
- Back-to-back MULs: second issues the cycle after exit, re-enters MUL_WAIT.

## Structure
- Shared package (define.v): state encodings, fwdSel codes, slot field widths, RegAddrReset.
- One sub-module: hazard_match (combinational rs vs. slot comparator, instanced per source × slot).

## Test plan
- Load x5 then add x6,x5,x1 → one cycle stallDec=1 + bubbleDecAlu=1, then add issues with fwdSel1=10.
- add x3 then sub x4,x3,x3 → no stall, fwdSel1=fwdSel2=01 next cycle.
- Write x0 then read x0 → fwdSel 00, no stall.
- MUL with MUL_LAT=4 → stallAlu high exactly 3 cycles, RUN on 4th.
- memReady held 0 for 5 cycles with load in MEM → all stalls high 5 cycles, branch in ALU ignored until release.
- aluBranchTaken coincident with load-use → flush wins: flushFetchDec=1, no stallDec; resetIn=0 during MUL_WAIT → RUN next cycle, stalls 0.
